// File: rtl/instr_decode_queue.sv
// instr_decode_queue
// Registered MIPS instruction decoder with a DEPTH-entry result queue.
// Each accepted word is decoded into a one-hot code plus an illegal flag.
// The result is stored with the raw word and its PC, and presented at the head.
// Optional feature macro: DECODE_STATS_EN adds pop and illegal-pop counters.
module instr_decode_queue #(
  parameter int CODE_W = 54,
  parameter int DEPTH  = 2,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_illegal,
  output logic [31:0]       out_instr,
  output logic [PC_W-1:0]   out_pc
`ifdef DECODE_STATS_EN
  ,
  output logic [31:0]       stat_decoded,
  output logic [31:0]       stat_illegal
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [5:0] opcode;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [5:0] funct;
  logic       unusedBits;

  logic [5:0]        decIdx;
  logic              decHit;
  logic              decLegal;
  logic [CODE_W-1:0] decCode;

  logic [CODE_W-1:0] codeMem_q  [DEPTH];
  logic              illMem_q   [DEPTH];
  logic [31:0]       instrMem_q [DEPTH];
  logic [PC_W-1:0]   pcMem_q    [DEPTH];

  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic push;
  logic pop;

  assign opcode     = in_instr[31:26];
  assign rs         = in_instr[25:21];
  assign rt         = in_instr[20:16];
  assign funct      = in_instr[5:0];
  assign unusedBits = ^in_instr[15:6];

  // Map the instruction fields to a bit index of the one-hot code table.
  always_comb begin
    decHit = 1'b1;
    decIdx = 6'd0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20: decIdx = 6'd0;
          6'h21: decIdx = 6'd1;
          6'h22: decIdx = 6'd2;
          6'h23: decIdx = 6'd3;
          6'h24: decIdx = 6'd4;
          6'h25: decIdx = 6'd5;
          6'h26: decIdx = 6'd6;
          6'h27: decIdx = 6'd7;
          6'h2A: decIdx = 6'd8;
          6'h2B: decIdx = 6'd9;
          6'h00: decIdx = 6'd10;
          6'h02: decIdx = 6'd11;
          6'h03: decIdx = 6'd12;
          6'h04: decIdx = 6'd13;
          6'h06: decIdx = 6'd14;
          6'h07: decIdx = 6'd15;
          6'h08: decIdx = 6'd16;
          6'h18: decIdx = 6'd37;
          6'h19: decIdx = 6'd38;
          6'h1A: decIdx = 6'd39;
          6'h1B: decIdx = 6'd40;
          6'h10: decIdx = 6'd41;
          6'h12: decIdx = 6'd42;
          6'h11: decIdx = 6'd43;
          6'h13: decIdx = 6'd44;
          6'h09: decIdx = 6'd45;
          6'h0C: decIdx = 6'd51;
          6'h0D: decIdx = 6'd52;
          6'h34: decIdx = 6'd53;
          default: decHit = 1'b0;
        endcase
      end
      6'h01: begin
        if (rt == 5'd1) decIdx = 6'd46;
        else            decHit = 1'b0;
      end
      6'h02: decIdx = 6'd29;
      6'h03: decIdx = 6'd30;
      6'h04: decIdx = 6'd25;
      6'h05: decIdx = 6'd26;
      6'h08: decIdx = 6'd17;
      6'h09: decIdx = 6'd18;
      6'h0A: decIdx = 6'd27;
      6'h0B: decIdx = 6'd28;
      6'h0C: decIdx = 6'd19;
      6'h0D: decIdx = 6'd20;
      6'h0E: decIdx = 6'd21;
      6'h0F: decIdx = 6'd22;
      6'h10: begin
        if (rs == 5'h10 && funct == 6'h18) decIdx = 6'd48;
        else if (rs == 5'h00)              decIdx = 6'd49;
        else if (rs == 5'h04)              decIdx = 6'd50;
        else                               decHit = 1'b0;
      end
      6'h1C: begin
        if (funct == 6'h20) decIdx = 6'd47;
        else                decHit = 1'b0;
      end
      6'h20: decIdx = 6'd31;
      6'h21: decIdx = 6'd33;
      6'h23: decIdx = 6'd23;
      6'h24: decIdx = 6'd32;
      6'h25: decIdx = 6'd34;
      6'h28: decIdx = 6'd35;
      6'h29: decIdx = 6'd36;
      6'h2B: decIdx = 6'd24;
      default: decHit = 1'b0;
    endcase
  end

  // An index beyond the configured code width is treated as unsupported.
  assign decLegal = decHit && (int'(decIdx) < CODE_W);

  // Expand the index into the one-hot code; unsupported words give all zeros.
  always_comb begin
    decCode = '0;
    for (int b = 0; b < CODE_W; b++) begin
      decCode[b] = decLegal && (int'(decIdx) == b);
    end
  end

  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Pointer and occupancy update; a flush overrides any push or pop.
  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (flush_i) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + PTR_W'(1);
      if (pop)  rdPtr_d = rdPtr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Queue control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  // Entry storage; cleared on reset so the head reads zero before any push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        codeMem_q[i]  <= '0;
        illMem_q[i]   <= 1'b0;
        instrMem_q[i] <= '0;
        pcMem_q[i]    <= '0;
      end
    end else if (push && !flush_i) begin
      codeMem_q[wrPtr_q]  <= decCode;
      illMem_q[wrPtr_q]   <= !decLegal;
      instrMem_q[wrPtr_q] <= in_instr;
      pcMem_q[wrPtr_q]    <= in_pc;
    end
  end

  assign out_code    = codeMem_q[rdPtr_q];
  assign out_illegal = illMem_q[rdPtr_q];
  assign out_instr   = instrMem_q[rdPtr_q];
  assign out_pc      = pcMem_q[rdPtr_q];

`ifdef DECODE_STATS_EN
  // Count consumed entries and consumed illegal entries; flush does not clear them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_decoded <= '0;
      stat_illegal <= '0;
    end else if (pop && !flush_i) begin
      stat_decoded <= stat_decoded + 32'd1;
      if (out_illegal) stat_illegal <= stat_illegal + 32'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_instr_decode_queue.sv
// tb_instr_decode_queue
// Directed and random checks of instr_decode_queue against a table-driven
// reference decoder and a queue model. Honors DECODE_STATS_EN when defined.
module tb_instr_decode_queue;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [63:0] code;
    logic        illegal;
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        inValid;
  logic        inReady;
  logic [31:0] inInstr;
  logic [31:0] inPc;
  logic        outValid;
  logic        outReady;
  logic [53:0] outCode;
  logic        outIllegal;
  logic [31:0] outInstr;
  logic [31:0] outPc;

  logic        inValid31;
  logic        inReady31;
  logic [31:0] inInstr31;
  logic        outValid31;
  logic        outReady31;
  logic [30:0] outCode31;
  logic        outIllegal31;
  logic [31:0] outInstr31;
  logic [31:0] outPc31;

`ifdef DECODE_STATS_EN
  logic [31:0] statDecoded;
  logic [31:0] statIllegal;
  logic [31:0] statDecoded31;
  logic [31:0] statIllegal31;
`endif

  logic [31:0] patMask [54];
  logic [31:0] patVal  [54];
  entry_t      model[$];
  logic [31:0] expDecoded;
  logic [31:0] expIllegal;
  int          nChecks;
  int          nFails;

  instr_decode_queue #(.CODE_W(54), .DEPTH(DEPTH), .PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .in_valid(inValid), .in_ready(inReady), .in_instr(inInstr), .in_pc(inPc),
    .out_valid(outValid), .out_ready(outReady), .out_code(outCode),
    .out_illegal(outIllegal), .out_instr(outInstr), .out_pc(outPc)
`ifdef DECODE_STATS_EN
    , .stat_decoded(statDecoded), .stat_illegal(statIllegal)
`endif
  );

  instr_decode_queue #(.CODE_W(31), .DEPTH(DEPTH), .PC_W(32)) dut31 (
    .clk(clk), .rst_n(rst_n), .flush_i(1'b0),
    .in_valid(inValid31), .in_ready(inReady31), .in_instr(inInstr31), .in_pc(32'h0),
    .out_valid(outValid31), .out_ready(outReady31), .out_code(outCode31),
    .out_illegal(outIllegal31), .out_instr(outInstr31), .out_pc(outPc31)
`ifdef DECODE_STATS_EN
    , .stat_decoded(statDecoded31), .stat_illegal(statIllegal31)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Fill the instruction pattern table (mask/value pairs, one per code bit).
  task automatic buildTable();
    byte unsigned rA[17] = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27,
                             8'h2A, 8'h2B, 8'h00, 8'h02, 8'h03, 8'h04, 8'h06, 8'h07, 8'h08};
    byte unsigned iA[14] = '{8'h08, 8'h09, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h23,
                             8'h2B, 8'h04, 8'h05, 8'h0A, 8'h0B, 8'h02, 8'h03};
    byte unsigned mA[6]  = '{8'h20, 8'h24, 8'h21, 8'h25, 8'h28, 8'h29};
    byte unsigned rB[9]  = '{8'h18, 8'h19, 8'h1A, 8'h1B, 8'h10, 8'h12, 8'h11, 8'h13, 8'h09};
    byte unsigned rC[3]  = '{8'h0C, 8'h0D, 8'h34};
    for (int i = 0; i < 17; i++) begin patMask[i] = 32'hFC00003F; patVal[i] = 32'(rA[i]); end
    for (int i = 0; i < 14; i++) begin patMask[17+i] = 32'hFC000000; patVal[17+i] = 32'(iA[i]) << 26; end
    for (int i = 0; i < 6; i++)  begin patMask[31+i] = 32'hFC000000; patVal[31+i] = 32'(mA[i]) << 26; end
    for (int i = 0; i < 9; i++)  begin patMask[37+i] = 32'hFC00003F; patVal[37+i] = 32'(rB[i]); end
    patMask[46] = 32'hFC1F0000; patVal[46] = (32'd1 << 26) | (32'd1 << 16);
    patMask[47] = 32'hFC00003F; patVal[47] = (32'h1C << 26) | 32'h20;
    patMask[48] = 32'hFFE0003F; patVal[48] = (32'h10 << 26) | (32'h10 << 21) | 32'h18;
    patMask[49] = 32'hFFE00000; patVal[49] = (32'h10 << 26);
    patMask[50] = 32'hFFE00000; patVal[50] = (32'h10 << 26) | (32'h04 << 21);
    for (int i = 0; i < 3; i++)  begin patMask[51+i] = 32'hFC00003F; patVal[51+i] = 32'(rC[i]); end
  endtask

  function automatic int refIndex(input logic [31:0] w);
    for (int i = 0; i < 54; i++) begin
      if ((w & patMask[i]) == patVal[i]) return i;
    end
    return -1;
  endfunction

  function automatic entry_t refEntry(input logic [31:0] w, input logic [31:0] pc, input int codeW);
    entry_t e;
    int idx;
    idx = refIndex(w);
    e.instr = w;
    e.pc = pc;
    if (idx >= 0 && idx < codeW) begin
      e.code = 64'd1 << idx;
      e.illegal = 1'b0;
    end else begin
      e.code = 64'd0;
      e.illegal = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] randWord();
    int k;
    k = $urandom_range(0, 63);
    if (k < 54) return patVal[k] | ($urandom() & ~patMask[k]);
    return $urandom();
  endfunction

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every visible DUT output with the reference model.
  task automatic checkModel();
    checkOutput("outValid", 64'(outValid), 64'(model.size() != 0));
    checkOutput("inReady", 64'(inReady), 64'(model.size() < DEPTH));
    if (model.size() != 0) begin
      checkOutput("headCode", 64'(outCode), model[0].code);
      checkOutput("headIllegal", 64'(outIllegal), 64'(model[0].illegal));
      checkOutput("headInstr", 64'(outInstr), 64'(model[0].instr));
      checkOutput("headPc", 64'(outPc), 64'(model[0].pc));
    end else begin
      checkOutput("noX", 64'($isunknown({outCode, outIllegal, outInstr, outPc})), 64'd0);
    end
`ifdef DECODE_STATS_EN
    checkOutput("statDecoded", 64'(statDecoded), 64'(expDecoded));
    checkOutput("statIllegal", 64'(statIllegal), 64'(expIllegal));
`endif
  endtask

  // Drive one cycle of inputs, check before the edge, then advance the model.
  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                               input logic rdy, input logic fl);
    logic doPush;
    logic doPop;
    inValid  = v;
    inInstr  = instr;
    inPc     = pc;
    outReady = rdy;
    flush    = fl;
    @(negedge clk);
    checkModel();
    doPush = v && (model.size() < DEPTH);
    doPop  = rdy && (model.size() != 0);
    @(posedge clk);
    #1;
    if (fl) begin
      model.delete();
    end else begin
      if (doPop) begin
        expDecoded++;
        if (model[0].illegal) expIllegal++;
        void'(model.pop_front());
      end
      if (doPush) model.push_back(refEntry(instr, pc, 54));
    end
    inValid = 1'b0;
    flush   = 1'b0;
  endtask

  // Push one word into the narrow-code instance and check its decode.
  task automatic checkNarrow(input string tag, input logic [31:0] w);
    entry_t e;
    e = refEntry(w, 32'h0, 31);
    inValid31  = 1'b1;
    inInstr31  = w;
    outReady31 = 1'b0;
    @(posedge clk);
    #1;
    inValid31 = 1'b0;
    checkOutput({tag, "Valid"}, 64'(outValid31), 64'd1);
    checkOutput({tag, "Code"}, 64'(outCode31), e.code);
    checkOutput({tag, "Illegal"}, 64'(outIllegal31), 64'(e.illegal));
    outReady31 = 1'b1;
    @(posedge clk);
    #1;
    outReady31 = 1'b0;
    checkOutput({tag, "Drained"}, 64'(outValid31), 64'd0);
  endtask

  initial begin
    nChecks = 0;
    nFails = 0;
    expDecoded = '0;
    expIllegal = '0;
    buildTable();
    rst_n = 1'b0;
    flush = 1'b0;
    inValid = 1'b0;
    inInstr = '0;
    inPc = '0;
    outReady = 1'b0;
    inValid31 = 1'b0;
    inInstr31 = '0;
    outReady31 = 1'b0;

    #12;
    $display("[TB] reset state");
    checkOutput("rstValid", 64'(outValid), 64'd0);
    checkOutput("rstReady", 64'(inReady), 64'd1);
    checkOutput("rstHead", 64'({outCode, outIllegal, outInstr} != '0) | 64'(outPc != '0), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single push, add");
    applyStimulus(1'b1, 32'h00221820, 32'h400, 1'b0, 1'b0);
    checkOutput("t1Valid", 64'(outValid), 64'd1);
    checkOutput("t1Code", 64'(outCode), 64'd1);
    checkOutput("t1Illegal", 64'(outIllegal), 64'd0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("[TB] fill with lw and jal");
    applyStimulus(1'b1, 32'h8C410004, 32'h404, 1'b0, 1'b0);
    checkOutput("t2CodeLw", 64'(outCode), 64'd1 << 23);
    applyStimulus(1'b1, 32'h0C000010, 32'h408, 1'b0, 1'b0);
    checkOutput("t2Full", 64'(inReady), 64'd0);
    checkOutput("t2Stable", 64'(outCode), 64'd1 << 23);

    $display("[TB] full queue with push and pop offered");
    applyStimulus(1'b1, 32'h00430018, 32'h40C, 1'b1, 1'b0);
    checkOutput("t3HeadJal", 64'(outCode), 64'd1 << 30);
    checkOutput("t3Ready", 64'(inReady), 64'd1);
    applyStimulus(1'b1, 32'h00430018, 32'h40C, 1'b1, 1'b0);
    checkOutput("t3HeadMult", 64'(outCode), 64'd1 << 37);
    checkOutput("t3CountOne", 64'(inReady), 64'd1);

    $display("[TB] illegal opcode");
    applyStimulus(1'b1, 32'hFC000000, 32'h410, 1'b1, 1'b0);
    checkOutput("t4Code", 64'(outCode), 64'd0);
    checkOutput("t4Illegal", 64'(outIllegal), 64'd1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("[TB] flush");
    applyStimulus(1'b1, 32'h00221820, 32'h500, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00221822, 32'h504, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h8C410004, 32'h508, 1'b1, 1'b1);
    checkOutput("t5Valid", 64'(outValid), 64'd0);
    checkOutput("t5Ready", 64'(inReady), 64'd1);
    applyStimulus(1'b1, 32'h0C000010, 32'h50C, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h8C410004, 32'h510, 1'b0, 1'b1);
    checkOutput("t5PushDropped", 64'(outValid), 64'd0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 3) != 0, randWord(), $urandom(),
                    $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    end

    $display("[TB] asynchronous reset mid-burst");
    applyStimulus(1'b1, 32'h00221820, 32'h600, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h8C410004, 32'h604, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6Valid", 64'(outValid), 64'd0);
    checkOutput("t6Code", 64'(outCode), 64'd0);
    checkOutput("t6Rest", 64'({outIllegal, outInstr, outPc} != '0), 64'd0);
    model.delete();
    expDecoded = '0;
    expIllegal = '0;
`ifdef DECODE_STATS_EN
    checkOutput("t6Stats", 64'({statDecoded, statIllegal}), 64'd0);
`endif
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 32'h0C000010, 32'h700, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("[TB] narrow code width");
    checkNarrow("nMult", 32'h00430018);
    checkNarrow("nAdd", 32'h00221820);
    checkNarrow("nJal", 32'h0C000010);
    checkNarrow("nLb", 32'h80000000);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
